// File: rtl/image_pkg.sv
// Shared types and helpers for the 3x3 window frame sequencer.
package image_pkg;

    localparam int COORD_W = 10;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        ACTIVE,
        FLUSH,
        DONE
    } state_t;

    // Bit positions inside win_edge = {top, bottom, left, right}.
    localparam int EDGE_TOP    = 3;
    localparam int EDGE_BOTTOM = 2;
    localparam int EDGE_LEFT   = 1;
    localparam int EDGE_RIGHT  = 0;

    typedef struct packed {
        logic               valid;
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [3:0]         edges;
    } win_info_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < value) r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/valid_delay_line.sv
// Fixed-depth shift register with synchronous clear; carries window
// descriptors alongside the generator's internal latency.
module valid_delay_line #(
    parameter int WIDTH = 25,
    parameter int DEPTH = 3
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage_q [DEPTH];

    // NOTE: sequential state uses non-blocking assignments so every stage
    // samples its predecessor's old value and the shift happens in one edge.
    // NOTE: the stages are cleared explicitly because a clear must drop
    // in-flight windows; this is a handful of flops, not a RAM.
    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
        end else begin
            stage_q[0] <= din;
            for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
        end
    end

    assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/image_matrix_ctrl.sv
// Frame sequencer for the 3x3 window generator: gates pixels in, pads the
// tail of each frame and tags every window with its center and border flags.
module image_matrix_ctrl
    import image_pkg::*;
#(
    parameter int IMG_HDISP = 640,
    parameter int IMG_VDISP = 480,
    parameter int PIPE_LAT  = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       per_frame_vsync,
    input  logic       per_frame_href,
    input  logic       per_image_clken,
    input  logic [7:0] per_image_gray,
    output logic       gen_clken,
    output logic [7:0] gen_gray,
    output logic       win_valid,
    output logic [9:0] win_x,
    output logic [9:0] win_y,
    output logic [3:0] win_edge,
    output logic       frame_done,
    output logic       frame_abort,
    output logic       busy
);

    localparam int PIX_W = clog2(IMG_HDISP * IMG_VDISP + 1);
    localparam int CNT_W = clog2(IMG_HDISP + 2);
    localparam int DRN_W = clog2(PIPE_LAT + 1);

    localparam logic [PIX_W-1:0]   PIX_LAST  = PIX_W'(IMG_HDISP * IMG_VDISP - 1);
    localparam logic [CNT_W-1:0]   FILL_LEN  = CNT_W'(IMG_HDISP + 1);
    localparam logic [DRN_W-1:0]   DRAIN_LEN = DRN_W'(PIPE_LAT);
    localparam logic [COORD_W-1:0] X_LAST    = COORD_W'(IMG_HDISP - 1);
    localparam logic [COORD_W-1:0] Y_LAST    = COORD_W'(IMG_VDISP - 1);

    state_t state_q, state_d;

    logic               vsync_q;
    logic               vs_rise, vs_fall;
    logic               accept;
    logic               in_frame;
    logic               abort;
    logic               cnt_clr;
    logic               clken_d;
    logic [7:0]         gray_d;

    logic [PIX_W-1:0]   pix_cnt;
    logic [CNT_W-1:0]   flush_cnt;
    logic [DRN_W-1:0]   drain_cnt;
    logic [CNT_W-1:0]   fill_cnt;
    logic [COORD_W-1:0] cx, cy;

    win_info_t          win_in, win_out;

    assign vs_rise  = per_frame_vsync & ~vsync_q;
    assign vs_fall  = ~per_frame_vsync & vsync_q;
    assign accept   = per_image_clken & per_frame_href;
    assign in_frame = (state_q == ACTIVE) || (state_q == FLUSH);
    assign abort    = vs_rise && in_frame;
    assign cnt_clr  = rst || abort || !in_frame;

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // NOTE: every signal written in a combinational block gets a default
    // first, so no path can leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:   if (vs_rise) state_d = ARM;
            ARM:    if (vs_fall) state_d = ACTIVE;
            ACTIVE: begin
                if (vs_rise)                            state_d = ARM;
                else if (accept && pix_cnt == PIX_LAST) state_d = FLUSH;
            end
            FLUSH: begin
                if (vs_rise)                                           state_d = ARM;
                else if (flush_cnt == FILL_LEN && drain_cnt == DRAIN_LEN) state_d = DONE;
            end
            DONE:    state_d = vs_rise ? ARM : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy       = 1'b0;
        frame_done = 1'b0;
        clken_d    = 1'b0;
        gray_d     = 8'h00;
        unique case (state_q)
            ARM: busy = 1'b1;
            ACTIVE: begin
                busy    = 1'b1;
                clken_d = accept && !vs_rise;
                if (accept) gray_d = per_image_gray;
            end
            FLUSH: begin
                busy    = 1'b1;
                clken_d = (flush_cnt != FILL_LEN) && !vs_rise;
            end
            DONE:    frame_done = 1'b1;
            default: busy = 1'b0;
        endcase
    end

    // The vsync edge register keeps tracking through reset so a vsync that
    // is already high when reset drops does not look like a fresh edge.
    always_ff @(posedge clk) begin
        vsync_q <= per_frame_vsync;
        if (rst) begin
            gen_clken   <= 1'b0;
            gen_gray    <= 8'h00;
            frame_abort <= 1'b0;
        end else begin
            gen_clken   <= clken_d;
            gen_gray    <= gray_d;
            frame_abort <= abort;
        end
    end

    // Pad clkens first, then PIPE_LAT+1 quiet cycles so DONE follows the last window.
    always_ff @(posedge clk) begin
        if (cnt_clr) begin
            pix_cnt   <= '0;
            flush_cnt <= '0;
            drain_cnt <= '0;
            fill_cnt  <= '0;
            cx        <= '0;
            cy        <= '0;
        end else begin
            if (state_q == ACTIVE && accept) pix_cnt <= pix_cnt + PIX_W'(1);
            if (state_q == FLUSH) begin
                if (flush_cnt != FILL_LEN)        flush_cnt <= flush_cnt + CNT_W'(1);
                else if (drain_cnt != DRAIN_LEN)  drain_cnt <= drain_cnt + DRN_W'(1);
            end
            if (gen_clken) begin
                if (fill_cnt != FILL_LEN) begin
                    fill_cnt <= fill_cnt + CNT_W'(1);
                end else if (cx == X_LAST) begin
                    cx <= '0;
                    cy <= (cy == Y_LAST) ? '0 : cy + COORD_W'(1);
                end else begin
                    cx <= cx + COORD_W'(1);
                end
            end
        end
    end

    always_comb begin
        win_in = '0;
        if (gen_clken && fill_cnt == FILL_LEN) begin
            win_in.valid              = 1'b1;
            win_in.x                  = cx;
            win_in.y                  = cy;
            win_in.edges[EDGE_TOP]    = (cy == '0);
            win_in.edges[EDGE_BOTTOM] = (cy == Y_LAST);
            win_in.edges[EDGE_LEFT]   = (cx == '0);
            win_in.edges[EDGE_RIGHT]  = (cx == X_LAST);
        end
    end

    valid_delay_line #(
        .WIDTH ($bits(win_info_t)),
        .DEPTH (PIPE_LAT)
    ) u_delay (
        .clk  (clk),
        .clr  (rst || abort),
        .din  (win_in),
        .dout (win_out)
    );

    assign win_valid = win_out.valid;
    assign win_x     = win_out.x;
    assign win_y     = win_out.y;
    assign win_edge  = win_out.edges;

endmodule
